// File: rtl/vscale_vec_lsu_pkg.sv
// Shared types and constants for the vscale vector load/store unit.
// Memory size codes match the scalar core's dmem interface.
package vscale_vec_lsu_pkg;

  localparam int XPR_LEN_DEF  = 32;
  localparam int VEC_SIZE_DEF = 4;

  localparam int MEM_TYPE_WIDTH = 3;
  localparam logic [MEM_TYPE_WIDTH-1:0] MEM_TYPE_B  = 3'd0;
  localparam logic [MEM_TYPE_WIDTH-1:0] MEM_TYPE_H  = 3'd1;
  localparam logic [MEM_TYPE_WIDTH-1:0] MEM_TYPE_W  = 3'd2;
  localparam logic [MEM_TYPE_WIDTH-1:0] MEM_TYPE_BU = 3'd4;
  localparam logic [MEM_TYPE_WIDTH-1:0] MEM_TYPE_HU = 3'd5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2,
    RESP = 2'd3
  } vlsu_state_t;

endpackage

// File: rtl/vscale_vec_lane_sel.sv
// Priority encoder: lowest set mask lane at or above idx.
// incl=0 searches strictly above idx, incl=1 includes idx.
module vscale_vec_lane_sel #(
  parameter int VEC_SIZE = 4,
  parameter int IW       = $clog2(VEC_SIZE)
) (
  input  logic [VEC_SIZE-1:0] mask,
  input  logic [IW-1:0]       idx,
  input  logic                incl,
  output logic                found,
  output logic [IW-1:0]       lane
);

  // scan downward so the lowest qualifying lane wins
  always_comb begin
    found = 1'b0;
    lane  = '0;
    for (int i = VEC_SIZE - 1; i >= 0; i--) begin
      if (mask[i] &&
          ((i > int'(idx)) ||
           (incl && (i == int'(idx))))) begin
        found = 1'b1;
        lane  = IW'(i);
      end
    end
  end

endmodule

// File: rtl/vscale_vec_lsu.sv
// Strided vector load/store unit driving the scalar dmem port,
// one lane access at a time (address phase then data phase).
module vscale_vec_lsu
  import vscale_vec_lsu_pkg::*;
#(
  parameter int XPR_LEN  = XPR_LEN_DEF,
  parameter int VEC_SIZE = VEC_SIZE_DEF,
  parameter int IW       = $clog2(VEC_SIZE)
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        req_valid,
  output logic                        req_ready,
  input  logic                        req_wen,
  input  logic [XPR_LEN-1:0]          req_base,
  input  logic [XPR_LEN-1:0]          req_stride,
  input  logic [VEC_SIZE-1:0]         req_mask,
  input  logic [VEC_SIZE*XPR_LEN-1:0] req_wdata,
  output logic                        resp_valid,
  input  logic                        resp_ready,
  output logic [VEC_SIZE*XPR_LEN-1:0] resp_rdata,
  output logic [VEC_SIZE-1:0]         resp_wmask,
  output logic                        resp_error,
  output logic [IW-1:0]               resp_err_idx,
  output logic                        dmem_en,
  output logic                        dmem_wen,
  output logic [MEM_TYPE_WIDTH-1:0]   dmem_size,
  output logic [XPR_LEN-1:0]          dmem_addr,
  output logic [XPR_LEN-1:0]          dmem_wdata_delayed,
  input  logic [XPR_LEN-1:0]          dmem_rdata,
  input  logic                        dmem_wait,
  input  logic                        dmem_badmem_e
);

  vlsu_state_t                state;
  logic                       wen_q;
  logic [XPR_LEN-1:0]         base_q;
  logic [XPR_LEN-1:0]         stride_q;
  logic [VEC_SIZE-1:0]        mask_q;
  logic [VEC_SIZE*XPR_LEN-1:0] wdata_q;
  logic [IW-1:0]              idx_q;

  logic                       first_found;
  logic [IW-1:0]              first_lane;
  logic                       next_found;
  logic [IW-1:0]              next_lane;
  logic                       misalign;

  vscale_vec_lane_sel #(
    .VEC_SIZE(VEC_SIZE),
    .IW      (IW)
  ) u_first_sel (
    .mask (req_mask),
    .idx  ({IW{1'b0}}),
    .incl (1'b1),
    .found(first_found),
    .lane (first_lane)
  );

  vscale_vec_lane_sel #(
    .VEC_SIZE(VEC_SIZE),
    .IW      (IW)
  ) u_next_sel (
    .mask (mask_q),
    .idx  (idx_q),
    .incl (1'b0),
    .found(next_found),
    .lane (next_lane)
  );

  assign misalign  = (|req_base[1:0]) |
                     (|req_stride[1:0]);
  assign req_ready = (state == IDLE) & reset;
  assign dmem_size = MEM_TYPE_W;

  // request sequencing and all registered outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state              <= IDLE;
      wen_q              <= 1'b0;
      base_q             <= '0;
      stride_q           <= '0;
      mask_q             <= '0;
      wdata_q            <= '0;
      idx_q              <= '0;
      resp_valid         <= 1'b0;
      resp_rdata         <= '0;
      resp_wmask         <= '0;
      resp_error         <= 1'b0;
      resp_err_idx       <= '0;
      dmem_en            <= 1'b0;
      dmem_wen           <= 1'b0;
      dmem_addr          <= '0;
      dmem_wdata_delayed <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (req_valid) begin
            wen_q        <= req_wen;
            base_q       <= req_base;
            stride_q     <= req_stride;
            mask_q       <= req_mask;
            wdata_q      <= req_wdata;
            resp_rdata   <= '0;
            resp_wmask   <= '0;
            resp_error   <= 1'b0;
            resp_err_idx <= '0;
            if (!first_found) begin
              state      <= RESP;
              resp_valid <= 1'b1;
            end else if (misalign) begin
              state        <= RESP;
              resp_valid   <= 1'b1;
              resp_error   <= 1'b1;
              resp_err_idx <= first_lane;
            end else begin
              state     <= ADDR;
              idx_q     <= first_lane;
              dmem_en   <= 1'b1;
              dmem_wen  <= req_wen;
              dmem_addr <= req_base +
                XPR_LEN'(first_lane) * req_stride;
            end
          end
        end
        ADDR: begin
          state              <= DATA;
          dmem_en            <= 1'b0;
          dmem_wen           <= 1'b0;
          dmem_wdata_delayed <=
            wdata_q[idx_q*XPR_LEN +: XPR_LEN];
        end
        DATA: begin
          if (!dmem_wait) begin
            dmem_wdata_delayed <= '0;
            if (dmem_badmem_e) begin
              state        <= RESP;
              resp_valid   <= 1'b1;
              resp_error   <= 1'b1;
              resp_err_idx <= idx_q;
            end else begin
              if (!wen_q) begin
                resp_rdata[idx_q*XPR_LEN +: XPR_LEN]
                  <= dmem_rdata;
              end
              resp_wmask[idx_q] <= 1'b1;
              if (next_found) begin
                state     <= ADDR;
                idx_q     <= next_lane;
                dmem_en   <= 1'b1;
                dmem_wen  <= wen_q;
                dmem_addr <= base_q +
                  XPR_LEN'(next_lane) * stride_q;
              end else begin
                state      <= RESP;
                resp_valid <= 1'b1;
              end
            end
          end
        end
        RESP: begin
          if (resp_ready) begin
            state      <= IDLE;
            resp_valid <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_vscale_vec_lsu.sv
// Bench for vscale_vec_lsu: vector table with a response scoreboard,
// a dmem responder model, and hand-written reset/hold sequences.
module tb_vscale_vec_lsu;

  localparam int XL = 32;
  localparam int VS = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic          req_wen = 1'b0;
  logic [31:0]   req_base = '0;
  logic [31:0]   req_stride = '0;
  logic [3:0]    req_mask = '0;
  logic [127:0]  req_wdata = '0;
  logic          resp_valid;
  logic          resp_ready = 1'b0;
  logic [127:0]  resp_rdata;
  logic [3:0]    resp_wmask;
  logic          resp_error;
  logic [1:0]    resp_err_idx;
  logic          dmem_en;
  logic          dmem_wen;
  logic [2:0]    dmem_size;
  logic [31:0]   dmem_addr;
  logic [31:0]   dmem_wdata_delayed;
  logic [31:0]   dmem_rdata = '0;
  logic          dmem_wait = 1'b0;
  logic          dmem_badmem_e = 1'b0;

  always #5 clk = ~clk;

  vscale_vec_lsu #(
    .XPR_LEN (XL),
    .VEC_SIZE(VS)
  ) dut (
    .clk               (clk),
    .reset             (reset),
    .req_valid         (req_valid),
    .req_ready         (req_ready),
    .req_wen           (req_wen),
    .req_base          (req_base),
    .req_stride        (req_stride),
    .req_mask          (req_mask),
    .req_wdata         (req_wdata),
    .resp_valid        (resp_valid),
    .resp_ready        (resp_ready),
    .resp_rdata        (resp_rdata),
    .resp_wmask        (resp_wmask),
    .resp_error        (resp_error),
    .resp_err_idx      (resp_err_idx),
    .dmem_en           (dmem_en),
    .dmem_wen          (dmem_wen),
    .dmem_size         (dmem_size),
    .dmem_addr         (dmem_addr),
    .dmem_wdata_delayed(dmem_wdata_delayed),
    .dmem_rdata        (dmem_rdata),
    .dmem_wait         (dmem_wait),
    .dmem_badmem_e     (dmem_badmem_e)
  );

  typedef struct {
    logic        wen;
    logic [31:0] base;
    logic [31:0] stride;
    logic [3:0]  mask;
    int          bad_lane;
    int          wait_lane;
    int          waits;
    int          hold;
    logic [3:0]  x_wmask;
    logic        x_err;
    logic [1:0]  x_idx;
    int          x_lat;
  } vec_t;

  typedef struct {
    logic [3:0]   wmask;
    logic         err;
    logic [1:0]   idx;
    logic [127:0] rdata;
    int           lat;
  } exp_t;

  localparam int NV = 10;
  vec_t tv[NV];
  exp_t sbq[$];

  int checks = 0;
  int passes = 0;

  task automatic chk(input string nm,
                     input logic [127:0] act,
                     input logic [127:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h want %0h",
                  nm, act, exp);
  endtask

  function automatic logic [31:0] memf(
    input logic [31:0] a);
    return {a[15:0] ^ 16'hC3A5, ~a[31:16]};
  endfunction

  function automatic logic [31:0] wd(input int v,
                                     input int i);
    return 32'hDA7A_0000 ^ 32'(v << 8) ^ 32'(i);
  endfunction

  function automatic logic [31:0] laddr(
    input vec_t t, input int i);
    return t.base + 32'(i) * t.stride;
  endfunction

  task automatic run_vec(input int v);
    vec_t         t;
    exp_t         e;
    exp_t         x;
    int           lq[$];
    int           n;
    int           cur;
    int           wl;
    bit           data;
    logic [127:0] snap_d;
    logic [7:0]   snap_c;
    t = tv[v];
    cur = 0;
    wl = 0;
    data = 0;
    for (int i = 0; i < VS; i++) begin
      if (t.mask[i]) lq.push_back(i);
    end
    if ((t.base[1:0] != 0) || (t.stride[1:0] != 0))
      lq.delete();
    if (t.bad_lane >= 0) begin
      while (lq.size() > 0 &&
             lq[lq.size()-1] > t.bad_lane)
        void'(lq.pop_back());
    end
    e.wmask = t.x_wmask;
    e.err   = t.x_err;
    e.idx   = t.x_idx;
    e.lat   = t.x_lat;
    e.rdata = '0;
    for (int i = 0; i < VS; i++) begin
      if (!t.wen && t.x_wmask[i])
        e.rdata[i*32 +: 32] = memf(laddr(t, i));
    end
    sbq.push_back(e);

    @(negedge clk);
    chk($sformatf("v%0d_req_ready", v), req_ready, 1);
    req_valid  = 1'b1;
    req_wen    = t.wen;
    req_base   = t.base;
    req_stride = t.stride;
    req_mask   = t.mask;
    for (int i = 0; i < VS; i++)
      req_wdata[i*32 +: 32] = wd(v, i);
    @(posedge clk);
    #1;
    req_valid  = 1'b0;
    req_wen    = ~t.wen;
    req_base   = $urandom;
    req_stride = $urandom;
    req_mask   = ~t.mask;
    req_wdata  = '1;

    n = 0;
    while (n < 200) begin
      @(negedge clk);
      n++;
      dmem_wait     = 1'b0;
      dmem_badmem_e = 1'b0;
      dmem_rdata    = $urandom;
      if (resp_valid) break;
      if (dmem_en) begin
        if (lq.size() == 0) begin
          chk($sformatf("v%0d_extra_access", v),
              dmem_addr, 0);
          cur = -1;
        end else begin
          cur = lq.pop_front();
          chk($sformatf("v%0d_addr%0d", v, cur),
              dmem_addr, laddr(t, cur));
          chk($sformatf("v%0d_wen%0d", v, cur),
              dmem_wen, t.wen);
        end
        data = 1;
        wl = (cur == t.wait_lane) ? t.waits : 0;
      end else if (data) begin
        chk($sformatf("v%0d_wdata%0d", v, cur),
            dmem_wdata_delayed, wd(v, cur));
        chk($sformatf("v%0d_addr_hold%0d", v, cur),
            dmem_addr, laddr(t, cur));
        if (wl > 0) begin
          dmem_wait = 1'b1;
          wl--;
        end else begin
          dmem_badmem_e = (cur == t.bad_lane);
          dmem_rdata    = memf(laddr(t, cur));
          data = 0;
        end
      end else begin
        chk($sformatf("v%0d_wdata_idle", v),
            dmem_wdata_delayed, 0);
      end
    end

    if (!resp_valid) begin
      chk($sformatf("v%0d_timeout", v), 0, 1);
      void'(sbq.pop_front());
      return;
    end
    x = sbq.pop_front();
    chk($sformatf("v%0d_latency", v), n, x.lat);
    chk($sformatf("v%0d_missed", v), lq.size(), 0);
    chk($sformatf("v%0d_wmask", v), resp_wmask, x.wmask);
    chk($sformatf("v%0d_error", v), resp_error, x.err);
    chk($sformatf("v%0d_err_idx", v),
        resp_err_idx, x.idx);
    chk($sformatf("v%0d_rdata", v), resp_rdata, x.rdata);
    chk($sformatf("v%0d_en_resp", v), dmem_en, 0);

    snap_d = resp_rdata;
    snap_c = {resp_valid, resp_error, resp_err_idx,
              resp_wmask};
    for (int h = 0; h < t.hold; h++) begin
      @(negedge clk);
      chk($sformatf("v%0d_hold_ctl%0d", v, h),
          {resp_valid, resp_error, resp_err_idx,
           resp_wmask}, snap_c);
      chk($sformatf("v%0d_hold_data%0d", v, h),
          resp_rdata, snap_d);
      chk($sformatf("v%0d_hold_busy%0d", v, h),
          req_ready, 0);
    end
    resp_ready = 1'b1;
    @(posedge clk);
    #1;
    resp_ready = 1'b0;
    @(negedge clk);
    chk($sformatf("v%0d_resp_drop", v), resp_valid, 0);
    chk($sformatf("v%0d_ready_back", v), req_ready, 1);
  endtask

  task automatic reset_mid();
    int n;
    @(negedge clk);
    req_valid  = 1'b1;
    req_wen    = 1'b0;
    req_base   = 32'h700;
    req_stride = 32'h4;
    req_mask   = 4'hF;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!dmem_en && n < 20);
    chk("rst_mid_addr_seen", dmem_en, 1);
    @(negedge clk);
    dmem_wait = 1'b1;
    chk("rst_mid_in_data", dmem_wdata_delayed,
        wd(99, 0));
    #2;
    reset = 1'b0;
    #1;
    chk("rst_mid_en", dmem_en, 0);
    chk("rst_mid_wdata", dmem_wdata_delayed, 0);
    chk("rst_mid_addr", dmem_addr, 0);
    chk("rst_mid_resp", {resp_valid, resp_error,
        resp_wmask}, 0);
    chk("rst_mid_rdata", resp_rdata, 0);
    chk("rst_mid_ready", req_ready, 0);
    @(posedge clk);
    #1;
    chk("rst_mid_hold", {dmem_en, resp_valid}, 0);
    @(negedge clk);
    dmem_wait = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    chk("rst_mid_ready_after", req_ready, 1);
    chk("rst_mid_no_resp", resp_valid, 0);
  endtask

  initial begin
    tv[0] = '{1'b0, 32'h100, 32'h4, 4'hF, -1, -1,
              0, 5, 4'hF, 1'b0, 2'd0, 9};
    tv[1] = '{1'b1, 32'h200, 32'h8, 4'hA, -1, -1,
              0, 0, 4'hA, 1'b0, 2'd0, 5};
    tv[2] = '{1'b0, 32'h300, 32'h4, 4'hF, 2, -1,
              0, 1, 4'h3, 1'b1, 2'd2, 7};
    tv[3] = '{1'b0, 32'h400, 32'h4, 4'h1, -1, 0,
              3, 0, 4'h1, 1'b0, 2'd0, 6};
    tv[4] = '{1'b0, 32'hFFFF_FFFC, 32'h4, 4'h3, -1,
              -1, 0, 0, 4'h3, 1'b0, 2'd0, 5};
    tv[5] = '{1'b0, 32'h102, 32'h4, 4'hF, -1, -1,
              0, 0, 4'h0, 1'b1, 2'd0, 1};
    tv[6] = '{1'b0, 32'h800, 32'h4, 4'h0, -1, -1,
              0, 2, 4'h0, 1'b0, 2'd0, 1};
    tv[7] = '{1'b1, 32'h500, 32'h6, 4'hC, -1, -1,
              0, 0, 4'h0, 1'b1, 2'd2, 1};
    tv[8] = '{1'b0, 32'h600, 32'hFFFF_FFF0, 4'h5,
              -1, 1, 0, 0, 4'h5, 1'b0, 2'd0, 5};
    tv[9] = '{1'b1, 32'h900, 32'h4, 4'h1, 0, 0,
              2, 0, 4'h0, 1'b1, 2'd0, 5};

    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready", req_ready, 0);
    chk("rst_resp", {resp_valid, resp_error,
        resp_err_idx, resp_wmask}, 0);
    chk("rst_rdata", resp_rdata, 0);
    chk("rst_dmem", {dmem_en, dmem_wen}, 0);
    chk("rst_addr", dmem_addr, 0);
    chk("rst_wdata", dmem_wdata_delayed, 0);
    chk("rst_size", dmem_size, 3'd2);
    @(negedge clk);
    reset = 1'b1;

    for (int v = 0; v < NV; v++) run_vec(v);

    for (int i = 0; i < VS; i++)
      req_wdata[i*32 +: 32] = wd(99, i);
    reset_mid();
    run_vec(0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
